// File: rtl/avalon_resp_pkg.sv
// Shared types for the Avalon-MM main-port responder: response codes, FSM states
// and the read-return entry carried through the latency pipe.
package avalon_resp_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_RSVD   = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } avs_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCEPT
    } avs_state_e;

    typedef struct packed {
        logic [63:0] data;
        avs_resp_e   resp;
    } rd_entry_t;

endpackage

// File: rtl/avalon_main_responder_mem_if.sv
// Avalon-MM 64-bit main data port bundle; master drives requests, slave answers.
interface avalon_main_responder_mem_if;

    logic [31:0] avs_address;
    logic [7:0]  avs_byteenable;
    logic        avs_read;
    logic        avs_write;
    logic [63:0] avs_writedata;
    logic        avs_waitrequest;
    logic [63:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [1:0]  avs_response;

    modport master (
        output avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
    );

    modport slave (
        input  avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
        output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
    );

endinterface

// File: rtl/avalon_resp_pipe.sv
// Fixed-depth read-return pipe: entries emerge exactly Depth cycles after push,
// in order. Only the valid bits are flushed by reset; payload follows valid.
module avalon_resp_pipe
    import avalon_resp_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  rd_entry_t entry_i,
    output logic      vld_o,
    output rd_entry_t entry_o
);

    logic [Depth-1:0] vld_q;
    rd_entry_t        ent_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= push_i;
            for (int i = 1; i < Depth; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        ent_q[0] <= entry_i;
        for (int i = 1; i < Depth; i++) begin
            ent_q[i] <= ent_q[i-1];
        end
    end

    assign vld_o   = vld_q[Depth-1];
    assign entry_o = ent_q[Depth-1];

endmodule

// File: rtl/avalon_main_responder_mem.sv
// Avalon-MM pipelined responder memory for the 64-bit main port: wait states,
// fixed read latency, outstanding-read limit, decode/slave errors.
// Optional macro AVS_ERR_INJECT_EN adds err_inject_i for forced SLVERR / dropped writes.
module avalon_main_responder_mem
    import avalon_resp_pkg::*;
#(
    parameter int unsigned MemBytes       = 65536,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned WaitStates     = 1,
    parameter int unsigned ReadLatency    = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
`ifdef AVS_ERR_INJECT_EN
    input  logic                        err_inject_i,
`endif
    avalon_main_responder_mem_if.slave  avs
);

    localparam int unsigned Words = MemBytes / 8;
    localparam int unsigned IdxW  = $clog2(Words);
    localparam logic [3:0]  WS_L  = 4'(WaitStates);
    localparam logic [3:0]  MAX_L = 4'(MaxOutstanding);
`ifdef AVS_ERR_INJECT_EN
    localparam logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
`endif

    logic [63:0] mem_q [Words];

    avs_state_e state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [3:0] outst_q, outst_d;

    logic            req, limit, waitreq, accept, rd_acc, wr_acc, mem_we, in_range;
    logic [31:0]     offset;
    logic [IdxW-1:0] idx;
    rd_entry_t       push_ent, rsp_ent;
    logic            rsp_vld;
    logic            unused_offset_bits;

    assign req      = avs.avs_read | avs.avs_write;
    // A return in this cycle frees a slot, so a new accept can overlap it.
    assign limit    = (outst_q == MAX_L) && !rsp_vld;
    assign offset   = avs.avs_address - BaseAddr;
    assign in_range = (avs.avs_address >= BaseAddr) && (offset < MemBytes);
    assign idx      = offset[IdxW+2:3];
    assign unused_offset_bits = ^{offset[2:0], offset[31:IdxW+3]};

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        waitreq = 1'b1;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WS_L == 4'd0) begin
                        waitreq = limit;
                        accept  = !limit;
                        if (limit) state_d = ST_ACCEPT;
                    end else if (WS_L == 4'd1) begin
                        state_d = ST_ACCEPT;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WS_L - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!req)                state_d = ST_IDLE;
                else if (wcnt_q == 4'd1) state_d = ST_ACCEPT;
                else                     wcnt_d  = wcnt_q - 4'd1;
            end
            ST_ACCEPT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    waitreq = limit;
                    accept  = !limit;
                    if (!limit) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Keep the bus stalled and the memory untouched while reset is asserted.
        if (!rst_ni) begin
            waitreq = 1'b1;
            accept  = 1'b0;
        end
    end

    assign rd_acc = accept & avs.avs_read;
    assign wr_acc = accept & avs.avs_write;

    always_comb begin
        outst_d = outst_q;
        if (rd_acc && !rsp_vld)      outst_d = outst_q + 4'd1;
        else if (!rd_acc && rsp_vld) outst_d = outst_q - 4'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            outst_q <= outst_d;
        end
    end

    always_comb begin
        push_ent.data = mem_q[idx];
        push_ent.resp = RESP_OKAY;
        if (avs.avs_read && avs.avs_write) begin
            push_ent.data = '0;
            push_ent.resp = RESP_SLVERR;
        end else if (!in_range) begin
            push_ent.data = '0;
            push_ent.resp = RESP_DECERR;
        end
`ifdef AVS_ERR_INJECT_EN
        if (err_inject_i) begin
            push_ent.data = ERR_DATA;
            push_ent.resp = RESP_SLVERR;
        end
`endif
    end

`ifdef AVS_ERR_INJECT_EN
    assign mem_we = wr_acc && !avs.avs_read && in_range && !err_inject_i;
`else
    assign mem_we = wr_acc && !avs.avs_read && in_range;
`endif

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (avs.avs_byteenable[b]) mem_q[idx][8*b +: 8] <= avs.avs_writedata[8*b +: 8];
            end
        end
    end

    avalon_resp_pipe #(
        .Depth (ReadLatency)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rd_acc),
        .entry_i (push_ent),
        .vld_o   (rsp_vld),
        .entry_o (rsp_ent)
    );

    assign avs.avs_waitrequest   = waitreq;
    assign avs.avs_readdatavalid = rsp_vld;
    assign avs.avs_readdata      = rsp_vld ? rsp_ent.data : '0;
    assign avs.avs_response      = rsp_vld ? rsp_ent.resp : RESP_OKAY;

endmodule

// File: tb/tb_avalon_main_responder_mem.sv
// Directed + randomized bench for avalon_main_responder_mem with a word-level memory model.
module tb_avalon_main_responder_mem;
    import avalon_resp_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MEMB = 65536;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    avalon_main_responder_mem_if a_if ();
    avalon_main_responder_mem_if b_if ();
    avalon_main_responder_mem_if c_if ();

`ifdef AVS_ERR_INJECT_EN
    logic inj_a = 1'b0;
`endif

    avalon_main_responder_mem #(.MemBytes(MEMB), .BaseAddr(BASE), .WaitStates(1),
                                .ReadLatency(2), .MaxOutstanding(4)) u_dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
`ifdef AVS_ERR_INJECT_EN
        .err_inject_i (inj_a),
`endif
        .avs    (a_if)
    );

    avalon_main_responder_mem #(.MemBytes(4096), .BaseAddr(BASE), .WaitStates(0),
                                .ReadLatency(2), .MaxOutstanding(1)) u_dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
`ifdef AVS_ERR_INJECT_EN
        .err_inject_i (1'b0),
`endif
        .avs    (b_if)
    );

    avalon_main_responder_mem #(.MemBytes(4096), .BaseAddr(BASE), .WaitStates(0),
                                .ReadLatency(3), .MaxOutstanding(4)) u_dut_c (
        .clk_i  (clk),
        .rst_ni (rst_n),
`ifdef AVS_ERR_INJECT_EN
        .err_inject_i (1'b0),
`endif
        .avs    (c_if)
    );

    // Reference memory for DUT A, keyed by word index.
    logic [63:0] mdl [int];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + MEMB);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [7:0] be, input logic [63:0] d);
        int w;
        logic [63:0] cur;
        if (in_rng(a)) begin
            w   = int'((a - BASE) / 8);
            cur = mdl.exists(w) ? mdl[w] : 64'hx;
            for (int b = 0; b < 8; b++) if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
            mdl[w] = cur;
        end
    endtask

    task automatic model_read(input logic [31:0] a, input bit rw,
                              output logic [63:0] d, output logic [1:0] r);
        if (rw) begin
            d = 64'h0; r = 2'b10;
        end else if (!in_rng(a)) begin
            d = 64'h0; r = 2'b11;
        end else begin
            d = mdl[int'((a - BASE) / 8)]; r = 2'b00;
        end
    endtask

    task automatic a_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [7:0] be, input logic [63:0] wd,
                          output int nwait, output bit ok);
        a_if.avs_address    = addr;
        a_if.avs_byteenable = be;
        a_if.avs_writedata  = wd;
        a_if.avs_read       = rd;
        a_if.avs_write      = wr;
        nwait = 0;
        ok    = 1'b0;
        while (!ok && nwait < 40) begin
            @(negedge clk);
            if (!a_if.avs_waitrequest) ok = 1'b1;
            else nwait++;
        end
        @(posedge clk);
        #1;
        a_if.avs_read  = 1'b0;
        a_if.avs_write = 1'b0;
    endtask

    task automatic a_collect(output logic [63:0] d, output logic [1:0] r,
                             output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        d   = 64'h0;
        r   = 2'b00;
        while (!ok && lat < 20) begin
            @(negedge clk);
            lat++;
            if (a_if.avs_readdatavalid) begin
                ok = 1'b1;
                d  = a_if.avs_readdata;
                r  = a_if.avs_response;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input string tag, input logic [31:0] addr,
                           input logic [7:0] be, input logic [63:0] wd);
        int n;
        bit ok;
        a_xfer(1'b0, 1'b1, addr, be, wd, n, ok);
        chk({tag, "_acc"}, 64'(ok), 64'd1);
        chk({tag, "_wait"}, 64'(n), 64'd1);
        model_write(addr, be, wd);
    endtask

    task automatic a_read(input string tag, input logic [31:0] addr,
                          input logic [7:0] be, input bit rw);
        int n, lat;
        bit ok;
        logic [63:0] ed, d;
        logic [1:0]  er, r;
        model_read(addr, rw, ed, er);
        a_xfer(1'b1, rw, addr, be, {$urandom, $urandom}, n, ok);
        chk({tag, "_acc"}, 64'(ok), 64'd1);
        chk({tag, "_wait"}, 64'(n), 64'd1);
        a_collect(d, r, lat, ok);
        chk({tag, "_rdv"}, 64'(ok), 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_data"}, d, ed);
        chk({tag, "_resp"}, 64'(r), 64'(er));
    endtask

    initial begin
        int          wset [16];
        logic [63:0] bdat [4];
        logic [63:0] bq_dat [$];
        int          bq_acc [$];
        int          n, nacc, nret, last;
        bit          got, acc_now, seen, pend;
        logic [31:0] ad;

        a_if.avs_address = '0; a_if.avs_byteenable = '0; a_if.avs_writedata = '0;
        a_if.avs_read = 1'b0;  a_if.avs_write = 1'b0;
        b_if.avs_address = '0; b_if.avs_byteenable = '0; b_if.avs_writedata = '0;
        b_if.avs_read = 1'b0;  b_if.avs_write = 1'b0;
        c_if.avs_address = '0; c_if.avs_byteenable = 8'hFF; c_if.avs_writedata = '0;
        c_if.avs_read = 1'b1;  c_if.avs_write = 1'b0;

        // Reset values (DUT C requests during reset to prove the stall is forced)
        repeat (2) @(negedge clk);
        chk("rst_waitreq_a", 64'(a_if.avs_waitrequest), 64'd1);
        chk("rst_rdv_a", 64'(a_if.avs_readdatavalid), 64'd0);
        chk("rst_rdata_a", a_if.avs_readdata, 64'd0);
        chk("rst_resp_a", 64'(a_if.avs_response), 64'd0);
        chk("rst_waitreq_c", 64'(c_if.avs_waitrequest), 64'd1);
        @(posedge clk);
        #1;
        c_if.avs_read = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write / read-back and single-cycle strobe
        a_write("wr10", 32'h10, 8'hFF, 64'h0123_4567_89AB_CDEF);
        a_read("rd10", 32'h10, 8'hFF, 1'b0);
        @(negedge clk);
        chk("rdv_strobe", 64'(a_if.avs_readdatavalid), 64'd0);
        @(posedge clk);
        #1;

        // Partial write, read through ignored low address bits
        a_write("wrpart", 32'h10, 8'h0F, 64'hFFFF_FFFF_1122_3344);
        a_read("rdpart", 32'h14, 8'h01, 1'b0);

        // Out-of-range read/write
        a_read("rd_oor", BASE + 32'(MEMB), 8'hFF, 1'b0);
        a_read("rd_top", 32'hFFFF_FFF8, 8'hFF, 1'b0);
        a_write("wr_oor", BASE + 32'(MEMB) + 32'h10, 8'hFF, 64'hAAAA_5555_AAAA_5555);
        a_read("rd_alias", 32'h10, 8'hFF, 1'b0);

        // Read and write together
        a_read("rdwr", 32'h10, 8'hFF, 1'b1);
        a_read("rd_after_rw", 32'h10, 8'hFF, 1'b0);

`ifdef AVS_ERR_INJECT_EN
        begin
            int ilat, in_w;
            bit iok;
            logic [63:0] id;
            logic [1:0]  ir;
            inj_a = 1'b1;
            a_xfer(1'b1, 1'b0, 32'h10, 8'hFF, 64'h0, in_w, iok);
            a_collect(id, ir, ilat, iok);
            chk("inj_rdv", 64'(iok), 64'd1);
            chk("inj_data", id, 64'hDEAD_BEEF_DEAD_BEEF);
            chk("inj_resp", 64'(ir), 64'd2);
            a_xfer(1'b0, 1'b1, 32'h10, 8'hFF, 64'h1234_5678_9ABC_DEF0, in_w, iok);
            inj_a = 1'b0;
            a_read("rd_after_inj", 32'h10, 8'hFF, 1'b0);
        end
`endif

        // Randomized traffic over a scattered word set
        for (int i = 0; i < 16; i++) begin
            wset[i] = i * 509 + int'($urandom_range(0, 400));
            a_write("pre", 32'(wset[i] * 8), 8'hFF, {$urandom, $urandom});
        end
        for (int i = 0; i < 40; i++) begin
            ad = 32'(wset[$urandom_range(0, 15)] * 8);
            case ($urandom_range(0, 4))
                0: a_write("rnd_wr", ad, 8'($urandom), {$urandom, $urandom});
                1: a_read("rnd_rd", ad, 8'($urandom), 1'b0);
                2: a_read("rnd_oor", BASE + 32'(MEMB) + 32'($urandom_range(0, 1000) * 8), 8'hFF, 1'b0);
                3: a_read("rnd_off", ad + 32'($urandom_range(0, 7)), 8'hFF, 1'b0);
                default: a_read("rnd_rw", ad, 8'hFF, 1'b1);
            endcase
        end

        // DUT B: zero wait states, one outstanding read, held read request
        for (int k = 0; k < 4; k++) begin
            bdat[k] = {$urandom, $urandom};
            b_if.avs_address = 32'(k * 8);
            b_if.avs_byteenable = 8'hFF;
            b_if.avs_writedata = bdat[k];
            b_if.avs_write = 1'b1;
            n = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                if (!b_if.avs_waitrequest) got = 1'b1;
                else n++;
            end
            chk("b_wr_acc", 64'(got), 64'd1);
            @(posedge clk);
            #1;
            b_if.avs_write = 1'b0;
        end
        b_if.avs_read = 1'b1;
        b_if.avs_address = 32'h0;
        nacc = 0; nret = 0; last = 0; n = 0;
        while ((nacc < 4 || nret < 4) && n < 60) begin
            @(negedge clk);
            n++;
            acc_now = 1'b0;
            pend = (bq_dat.size() != 0);
            if (b_if.avs_readdatavalid) begin
                chk("b_ret_expected", 64'(pend), 64'd1);
                if (pend) begin
                    chk("b_ret_data", b_if.avs_readdata, bq_dat.pop_front());
                    chk("b_ret_lat", 64'(cyc - bq_acc.pop_front()), 64'd2);
                    chk("b_ret_resp", 64'(b_if.avs_response), 64'd0);
                    nret++;
                end
            end else if (pend) begin
                chk("b_limit_wait", 64'(b_if.avs_waitrequest), 64'd1);
            end
            if (b_if.avs_read && !b_if.avs_waitrequest) begin
                if (nacc > 0) chk("b_spacing", 64'(cyc - last), 64'd2);
                last = cyc;
                bq_acc.push_back(cyc);
                bq_dat.push_back(bdat[nacc]);
                nacc++;
                acc_now = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                if (nacc == 4) b_if.avs_read = 1'b0;
                else b_if.avs_address = 32'(nacc * 8);
            end
        end
        chk("b_done", 64'(nret), 64'd4);

        // DUT C: reset with two reads in flight
        c_if.avs_read = 1'b1;
        nacc = 0; n = 0;
        while (nacc < 2 && n < 20) begin
            @(negedge clk);
            n++;
            if (!c_if.avs_waitrequest) nacc++;
        end
        chk("c_acc", 64'(nacc), 64'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("c_wait_rst", 64'(c_if.avs_waitrequest), 64'd1);
        chk("c_rdv_rst", 64'(c_if.avs_readdatavalid), 64'd0);
        @(posedge clk);
        #1;
        c_if.avs_read = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (c_if.avs_readdatavalid) seen = 1'b1;
        end
        chk("c_no_stale_rdv", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_main_responder_mem.md
Name: avalon_main_responder_mem

Overview:
- Avalon-MM pipelined slave (responder) for the 64-bit main data port driven by the ibex core's Avalon translator.
- Byte-addressed, 8-byte-word memory with programmable wait states, fixed read latency, an outstanding-read limit and error responses.
- Used as the simulation/FPGA memory behind avm_main_* and as the bench-side model for translator verification.

Parameters:
MemBytes, 65536, memory size in bytes; power of two, multiple of 8
BaseAddr, 32'h0000_0000, byte address of the first memory word; 8-byte aligned
WaitStates, 1, cycles avs_waitrequest is held high before each acceptance (0..15)
ReadLatency, 2, cycles from read acceptance to avs_readdatavalid (1..8)
MaxOutstanding, 4, maximum reads accepted but not yet returned (1..8)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
avs_address  in  32  byte address; bits [2:0] ignored
avs_byteenable  in  8  byte lane enables; lane i = writedata[8i+7:8i]
avs_read  in  1  read request
avs_write  in  1  write request
avs_writedata  in  64  write data
avs_waitrequest  out  1  stall; request accepted when (read|write) && !waitrequest
avs_readdata  out  64  read data, valid with readdatavalid
avs_readdatavalid  out  1  one-cycle read return strobe
avs_response  out  2  00 OKAY, 10 SLVERR, 11 DECODEERR; valid with readdatavalid

Behaviour:
- Reset: avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, avs_response=00; wait counter and outstanding count 0; read pipe flushed. Memory contents are not reset.
- Reset mid-operation: all in-flight reads are discarded, and no readdatavalid is issued for them.
- FSM IDLE/WAIT/ACCEPT:
  - IDLE: waitrequest=1 when no request.
  - IDLE, request present: go to WAIT with counter=WaitStates. If WaitStates=0, go directly to ACCEPT in the same cycle (waitrequest=0 combinationally).
  - WAIT: decrement counter each cycle; at 0 go to ACCEPT.
  - ACCEPT: waitrequest=0 for exactly one cycle, request is accepted, then return to IDLE.
  - Request dropped during WAIT: return to IDLE; nothing is accepted.
- Outstanding limit: waitrequest is forced to 1 whenever outstanding==MaxOutstanding. This gates ACCEPT; the FSM holds in ACCEPT until the limit clears.
- Outstanding counter: +1 on read accept, -1 on readdatavalid; both in the same cycle leaves it unchanged.
- Address decode: in range iff BaseAddr <= address < BaseAddr+MemBytes; word index = (address-BaseAddr)>>3.
- Write accept:
  - In range: bytes with byteenable=1 are updated at the accept clock edge.
  - Out of range: dropped silently (Avalon has no write response here).
  - byteenable=0: accepted, no update.
- Read accept:
  - An entry {data, resp} is pushed into the pipe and captured at acceptance.
  - Returns exactly ReadLatency cycles later, always in order.
  - In range: the full 64-bit word is returned regardless of byteenable, with resp OKAY.
  - Out of range: data 0, resp DECODEERR.
- Read immediately after a write to the same word returns the new data; the write commits before any later acceptance.
- Read and write both asserted: accepted as one transaction, no memory update, read returns data 0 with SLVERR.
- readdatavalid can coincide with a new acceptance; there is no bubble.

Optional Feature:
- Macro AVS_ERR_INJECT_EN.
- Defined: adds input err_inject_i (1 bit). A read accepted while err_inject_i=1 returns SLVERR with data 64'hDEAD_BEEF_DEAD_BEEF. A write accepted while err_inject_i=1 is dropped.
- Undefined: no port and no injection logic; behaviour is exactly as above.

Decomposition:
- Package avalon_resp_pkg:
  - avs_resp_e enum {RESP_OKAY=2'b00, RESP_RSVD=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11}
  - FSM state enum
  - struct rd_entry_t {logic [63:0] data; avs_resp_e resp;}
- Sub-module avalon_resp_pipe: fixed-depth (ReadLatency) valid-qualified shift register of rd_entry_t with asynchronous active-low flush.

Test Plan:
- Reset then single write: write 0x0123456789ABCDEF to 0x10 with be=0xFF, WaitStates=1 -> waitrequest high 1 cycle, low 1 cycle. Read 0x10 -> readdatavalid 2 cycles after accept, data 0x0123456789ABCDEF, resp 00.
- Partial write: be=0x0F with data 0xFFFFFFFF_11223344 over 0x10 -> read returns 0x01234567_11223344.
- Out of range: read at BaseAddr+MemBytes -> data 0, resp 11. Write there, then read an in-range alias -> in-range data unchanged.
- Back-to-back reads held continuously with WaitStates=0, MaxOutstanding=1, ReadLatency=2 -> waitrequest=1 while 1 is outstanding; one accept per 2 cycles; returns in order.
- Read+write asserted together -> resp 10, data 0, memory unchanged. Assert rst_ni=0 with 2 reads in flight -> no readdatavalid after release; waitrequest=1 during reset.
- With AVS_ERR_INJECT_EN: err_inject_i=1 on a read of 0x10 -> resp 10, data 0xDEADBEEFDEADBEEF.
